ring_sequence_checker: RTL and testbench
========================================

# ring_sequence_checker

Receive-side companion to the 4-bit synchronous ring counter. It samples a ring-coded bus and decodes the one-hot value to a binary index. It also acquires lock on the rotation sequence and flags and counts sequence or coding errors once locked. It sits downstream of any ring-counter output, either as a self-check monitor in the counter's bench or as a decoder in datapath logic.

## Interface
- `WIDTH`, default 4: ring length and `q_in` width; must be ≥ 2.
- `LOCK_COUNT`, default 2: consecutive correct transitions required to declare lock; must be ≥ 1.
- `CNT_W`, default 8: width of the saturating error counter.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `en`  in  1: sample strobe; `q_in` is evaluated only when high.
- `q_in`  in  WIDTH: ring-coded input; legal values are one-hot, rotating left (0001→0010→0100→1000→0001).
- `err_clr`  in  1: synchronous clear of `err_count`.
- `idx`  out  $clog2(WIDTH): binary position of the set bit in the last valid sample.
- `idx_valid`  out  1: `idx` updated this cycle.
- `locked`  out  1: sequence lock achieved.
- `err_pulse`  out  1: one-cycle error flag.
- `err_count`  out  CNT_W: saturating error count.

## Operation
- One-hot check is combinational on `q_in`: exactly one bit set. All-zero and multi-hot are illegal.
- Expected next value = `prev` rotated left by 1, with bit WIDTH-1 wrapping to bit 0.
- FSM states and transitions:
  - SEARCH:
    - `en` with a legal sample → store `prev`, set `match_cnt`=0, go to ACQUIRE.
    - `en` with an illegal sample → stay in SEARCH.
  - ACQUIRE:
    - `en` with sample == expected → `match_cnt`++ and update `prev`. Go to LOCKED when `match_cnt` reaches LOCK_COUNT.
    - `en` with a legal but unexpected sample → reload `prev`, set `match_cnt`=0, stay in ACQUIRE.
    - `en` with an illegal sample → go to SEARCH.
    - No errors are counted in ACQUIRE.
  - LOCKED:
    - `en` with sample == expected → update `prev`.
    - `en` with any other value (illegal or wrong position) → `err_pulse`=1, `err_count`++, go to SEARCH.
- `en`=0 in any state: state, `prev` and `match_cnt` hold; `idx_valid`=0 and `err_pulse`=0.
- `idx`, `idx_valid`:
  - Updated on every `en` with a legal sample, in any state.
  - On an illegal sample, `idx` holds its previous value and `idx_valid`=0.
- `err_count`:
  - Saturates at 2^CNT_W−1.
  - `err_clr` together with an error in the same cycle → count = 1; the error is never lost.
  - `err_clr` alone → 0.
- Reset mid-operation: everything returns to reset values on the next edge; no error is counted.

## Timing
- All outputs are registered.
- Reset values: `idx`=0, `idx_valid`=0, `locked`=0, `err_pulse`=0, `err_count`=0, FSM=SEARCH, `prev`=0, `match_cnt`=0.
- Decode latency is 1 cycle: a sample with `en` at edge N appears on `idx`/`idx_valid` after edge N.
- Lock latency: with samples on consecutive `en`s, `locked` rises after the edge that samples the (LOCK_COUNT+1)-th sample.
- `locked` falls, and `err_pulse` rises, after the edge that samples the offending value. `err_count` increments on that same edge.
- Back-to-back `en` is supported every cycle; no throughput bubbles.

## Structure
- Shared package `ring_pkg`:
  - FSM state enum {SEARCH, ACQUIRE, LOCKED}.
  - Functions `is_onehot`, `rotl1` and `onehot_to_idx`, also reusable by the ring counter bench.
- One natural sub-module: `onehot_decoder`, a combinational legal flag plus index for WIDTH bits. The FSM and counters stay in the top module.

## Test plan
- Reset, then feed the ring counter output (0001,0010,0100,1000,0001,…) with `en`=1 every cycle:
  - `idx` = 0,1,2,3,0.
  - `locked`=1 after the 3rd sample edge.
  - `err_count` stays 0.
- Locked, then inject 0101:
  - `err_pulse` for exactly one cycle, `err_count`=1, `locked`=0, `idx` holds 3.
  - Re-lock after 3 correct samples.
- Locked at 0010, then feed 1000 (position skip):
  - Error counted and `locked` drops.
  - `idx`=3 with `idx_valid`=1.
- Feed 0000 and 1100 while in SEARCH: no `err_pulse`, `idx_valid`=0, state stays SEARCH.
- Toggle `en` low for 5 cycles mid-sequence while locked:
  - `locked` holds, no error.
  - Resuming with the correct next value keeps lock.
- Error counter:
  - Force 255 errors, then one more: `err_count` stays 255.
  - `err_clr` with a simultaneous error: `err_count`=1.
  - Assert `reset` while locked: all outputs 0 on the next edge.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for ring-coded sequence handling: FSM states and
// one-hot helper functions. The ring counter bench can reuse these too.
package ring_pkg;

    // Widest ring the helper functions handle. Callers zero-extend narrower vectors.
    localparam int RING_MAX_W     = 64;
    localparam int RING_IDX_MAX_W = 6;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_e;

    // Returns 1 when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [RING_MAX_W-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            ones = ones + 32'(v[i]);
        end
        return (ones == 1);
    endfunction

    // Rotates the low 'width' bits of v left by one; bit width-1 wraps to bit 0.
    function automatic logic [RING_MAX_W-1:0] rotl1(input logic [RING_MAX_W-1:0] v,
                                                    input int width);
        logic [RING_MAX_W-1:0] r;
        r = '0;
        for (int j = 1; j < RING_MAX_W; j++) begin
            if (j < width) begin
                r[j] = v[j-1];
            end
        end
        r[0] = v[width-1];
        return r;
    endfunction

    // Binary position of the set bit. Only meaningful for one-hot input.
    function automatic logic [RING_IDX_MAX_W-1:0] onehot_to_idx(input logic [RING_MAX_W-1:0] v);
        logic [RING_IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (v[i]) begin
                idx = idx | RING_IDX_MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational one-hot legality check and binary index for a WIDTH-bit vector.
module onehot_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    // Zero-extend into the shared helpers; the index is narrowed back to IDX_W.
    always_comb begin
        legal = is_onehot(RING_MAX_W'(vec));
        idx   = IDX_W'(onehot_to_idx(RING_MAX_W'(vec)));
    end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side checker for a ring counter: decodes the one-hot sample to an
// index, acquires lock on the left rotation and counts errors once locked.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         err_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int MC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_COUNT - 1);

    ring_state_e      state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             legal;
    logic [IDX_W-1:0] dec_idx;
    logic [WIDTH-1:0] expected;

    onehot_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .vec   (q_in),
        .legal (legal),
        .idx   (dec_idx)
    );

    // The value the ring should present next, given the last accepted sample.
    always_comb begin
        expected = WIDTH'(rotl1(RING_MAX_W'(prev_q), WIDTH));
    end

    // Lock FSM next state, index decode and error detection.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        err_pulse_d = 1'b0;

        if (en) begin
            if (legal) begin
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
            end

            case (state_q)
                SEARCH: begin
                    if (legal) begin
                        prev_d      = q_in;
                        match_cnt_d = '0;
                        state_d     = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (!legal) begin
                        state_d = SEARCH;
                    end else if (q_in == expected) begin
                        prev_d      = q_in;
                        match_cnt_d = match_cnt_q + MC_W'(1);
                        if (match_cnt_q == MC_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        // Legal but out of order: restart acquisition from this sample.
                        prev_d      = q_in;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (legal && (q_in == expected)) begin
                        prev_d = q_in;
                    end else begin
                        err_pulse_d = 1'b1;
                        state_d     = SEARCH;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // Saturating error counter; a clear coinciding with an error keeps that error.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr && err_pulse_d) begin
            err_count_d = CNT_W'(1);
        end else if (err_clr) begin
            err_count_d = '0;
        end else if (err_pulse_d && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            prev_q      <= '0;
            match_cnt_q <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: directed scenarios plus randomized traffic
// compared against a behavioural model of lock/error/decode rules.
module tb_ring_sequence_checker;

    localparam int W  = 4;
    localparam int LC = 2;
    localparam int CW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  q_in = '0;
    logic          err_clr = 1'b0;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model variables
    logic [IW-1:0] m_idx = '0;
    logic          m_vld = 1'b0;
    logic          m_locked = 1'b0;
    logic          m_pulse = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_have = 1'b0;
    logic [W-1:0]  m_prev = '0;
    int            m_run = 0;

    ring_sequence_checker #(
        .WIDTH      (W),
        .LOCK_COUNT (LC),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .q_in      (q_in),
        .err_clr   (err_clr),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rot(input logic [W-1:0] p);
        return W'((p << 1) | (p >> (W - 1)));
    endfunction

    function automatic int pos(input logic [W-1:0] q);
        for (int i = 0; i < W; i++) begin
            if (q[i]) return i;
        end
        return 0;
    endfunction

    // Model of one clock edge, written from the behavioural rules.
    task automatic model_step(input logic r, input logic e, input logic [W-1:0] q, input logic c);
        logic legal;
        if (r) begin
            m_idx = '0; m_vld = 0; m_locked = 0; m_pulse = 0; m_cnt = '0;
            m_have = 0; m_prev = '0; m_run = 0;
            return;
        end
        m_pulse = 0;
        m_vld   = 0;
        if (e) begin
            legal = ($countones(q) == 1);
            if (legal) begin
                m_idx = IW'(pos(q));
                m_vld = 1;
            end
            if (m_locked) begin
                if (q == rot(m_prev)) m_prev = q;
                else begin
                    m_pulse = 1; m_locked = 0; m_have = 0;
                end
            end else if (m_have) begin
                if (!legal) m_have = 0;
                else if (q == rot(m_prev)) begin
                    m_prev = q;
                    m_run  = m_run + 1;
                    if (m_run == LC) m_locked = 1;
                end else begin
                    m_prev = q;
                    m_run  = 0;
                end
            end else if (legal) begin
                m_have = 1; m_prev = q; m_run = 0;
            end
        end
        if (m_pulse && c) m_cnt = 1;
        else if (c) m_cnt = 0;
        else if (m_pulse && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
    endtask

    // Drive one cycle of inputs, advance the model, settle past the edge.
    task automatic cycle(input logic r, input logic e, input logic [W-1:0] q, input logic c);
        reset = r; en = e; q_in = q; err_clr = c;
        @(posedge clk);
        model_step(r, e, q, c);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, 0);
        cycle(1, 1, 4'b0001, 0);
        checks++;
        if ({idx, idx_valid, locked, err_pulse, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_values act idx=%0d vld=%b lk=%b pulse=%b cnt=%0d exp all 0",
                     idx, idx_valid, locked, err_pulse, err_count);
        end
    endtask

    task automatic test_ring_lock();
        logic [W-1:0]  seq[5];
        logic [IW-1:0] e_idx[5];
        logic          e_lk[5];
        seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        e_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        e_lk  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, seq[k], 0);
            checks++;
            if (idx !== e_idx[k] || idx_valid !== 1'b1 || locked !== e_lk[k] ||
                err_pulse !== 1'b0 || err_count !== 8'd0) begin
                failures++;
                $display("FAIL ring_lock[%0d] act idx=%0d vld=%b lk=%b pulse=%b cnt=%0d exp idx=%0d vld=1 lk=%b pulse=0 cnt=0",
                         k, idx, idx_valid, locked, err_pulse, err_count, e_idx[k], e_lk[k]);
            end
        end
    endtask

    task automatic test_bad_code();
        logic [W-1:0] relock[3];
        logic         e_lk[3];
        cycle(0, 1, 4'b0010, 0);
        cycle(0, 1, 4'b0100, 0);
        cycle(0, 1, 4'b1000, 0);
        cycle(0, 1, 4'b0101, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 ||
            idx !== 2'd3 || idx_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_code act pulse=%b cnt=%0d lk=%b idx=%0d vld=%b exp 1 1 0 3 0",
                     err_pulse, err_count, locked, idx, idx_valid);
        end
        relock = '{4'b0001, 4'b0010, 4'b0100};
        e_lk   = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, relock[k], 0);
            checks++;
            if (err_pulse !== 1'b0 || locked !== e_lk[k] || err_count !== 8'd1) begin
                failures++;
                $display("FAIL relock[%0d] act pulse=%b lk=%b cnt=%0d exp pulse=0 lk=%b cnt=1",
                         k, err_pulse, locked, err_count, e_lk[k]);
            end
        end
    endtask

    task automatic test_skip();
        cycle(0, 1, 4'b1000, 0);
        cycle(0, 1, 4'b0001, 0);
        cycle(0, 1, 4'b0010, 0);
        checks++;
        if (locked !== 1'b1 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL skip_pre act lk=%b pulse=%b exp lk=1 pulse=0", locked, err_pulse);
        end
        cycle(0, 1, 4'b1000, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0 ||
            idx !== 2'd3 || idx_valid !== 1'b1) begin
            failures++;
            $display("FAIL skip act pulse=%b cnt=%0d lk=%b idx=%0d vld=%b exp 1 2 0 3 1",
                     err_pulse, err_count, locked, idx, idx_valid);
        end
    endtask

    task automatic test_search_illegal();
        logic [W-1:0] bad[2];
        bad = '{4'b0000, 4'b1100};
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, bad[k], 0);
            checks++;
            if (err_pulse !== 1'b0 || idx_valid !== 1'b0 || locked !== 1'b0 ||
                idx !== 2'd3 || err_count !== 8'd2) begin
                failures++;
                $display("FAIL search_illegal[%0d] act pulse=%b vld=%b lk=%b idx=%0d cnt=%0d exp 0 0 0 3 2",
                         k, err_pulse, idx_valid, locked, idx, err_count);
            end
        end
        cycle(0, 1, 4'b0001, 0);
        cycle(0, 1, 4'b0010, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL search_acq act lk=%b exp lk=0", locked);
        end
        cycle(0, 1, 4'b0100, 0);
        checks++;
        if (locked !== 1'b1 || idx !== 2'd2) begin
            failures++;
            $display("FAIL search_lock act lk=%b idx=%0d exp lk=1 idx=2", locked, idx);
        end
    endtask

    task automatic test_en_gap();
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, W'($urandom), 0);
            checks++;
            if (locked !== 1'b1 || err_pulse !== 1'b0 || idx_valid !== 1'b0 ||
                idx !== 2'd2 || err_count !== 8'd2) begin
                failures++;
                $display("FAIL en_gap[%0d] act lk=%b pulse=%b vld=%b idx=%0d cnt=%0d exp 1 0 0 2 2",
                         k, locked, err_pulse, idx_valid, idx, err_count);
            end
        end
        cycle(0, 1, 4'b1000, 0);
        checks++;
        if (locked !== 1'b1 || err_pulse !== 1'b0 || idx !== 2'd3 || idx_valid !== 1'b1) begin
            failures++;
            $display("FAIL en_resume act lk=%b pulse=%b idx=%0d vld=%b exp 1 0 3 1",
                     locked, err_pulse, idx, idx_valid);
        end
    endtask

    task automatic test_err_counter();
        cycle(0, 0, '0, 1);
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL clr_only act cnt=%0d exp 0", err_count);
        end
        for (int n = 0; n < 256; n++) begin
            cycle(0, 1, 4'b0001, 0);
            cycle(0, 1, 4'b0010, 0);
            cycle(0, 1, 4'b0100, 0);
            cycle(0, 1, 4'b0000, 0);
            if (n == 0 || n == 254 || n == 255) begin
                checks++;
                if (err_count !== CW'((n >= 254) ? 255 : n + 1) || err_pulse !== 1'b1) begin
                    failures++;
                    $display("FAIL err_sat[%0d] act cnt=%0d pulse=%b exp cnt=%0d pulse=1",
                             n, err_count, err_pulse, (n >= 254) ? 255 : n + 1);
                end
            end
        end
        cycle(0, 1, 4'b0001, 0);
        cycle(0, 1, 4'b0010, 0);
        cycle(0, 1, 4'b0100, 0);
        cycle(0, 1, 4'b0110, 1);
        checks++;
        if (err_count !== 8'd1 || err_pulse !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_err act cnt=%0d pulse=%b exp cnt=1 pulse=1", err_count, err_pulse);
        end
        cycle(0, 0, '0, 1);
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL clr_after act cnt=%0d exp 0", err_count);
        end
    endtask

    task automatic test_reset_locked();
        cycle(0, 1, 4'b0001, 0);
        cycle(0, 1, 4'b0010, 0);
        cycle(0, 1, 4'b0100, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL reset_locked_pre act lk=%b exp 1", locked);
        end
        cycle(1, 1, 4'b0101, 0);
        checks++;
        if ({idx, idx_valid, locked, err_pulse, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_locked act idx=%0d vld=%b lk=%b pulse=%b cnt=%0d exp all 0",
                     idx, idx_valid, locked, err_pulse, err_count);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] last;
        logic [W-1:0] q;
        logic         r, e, c;
        int           kind;
        last = 4'b0001;
        for (int k = 0; k < 1500; k++) begin
            r    = ($urandom_range(0, 99) == 0);
            e    = ($urandom_range(0, 9) != 0);
            c    = ($urandom_range(0, 19) == 0);
            kind = $urandom_range(0, 9);
            if (kind < 7)       q = rot(last);
            else if (kind == 7) q = W'(1) << $urandom_range(0, W - 1);
            else                q = W'($urandom);
            if (e && $countones(q) == 1) last = q;
            cycle(r, e, q, c);
            checks++;
            if ({idx, idx_valid, locked, err_pulse, err_count} !==
                {m_idx, m_vld, m_locked, m_pulse, m_cnt}) begin
                failures++;
                $display("FAIL random[%0d] q=%b en=%b act idx=%0d vld=%b lk=%b pulse=%b cnt=%0d exp idx=%0d vld=%b lk=%b pulse=%b cnt=%0d",
                         k, q, e, idx, idx_valid, locked, err_pulse, err_count,
                         m_idx, m_vld, m_locked, m_pulse, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring_lock();
        test_bad_code();
        test_skip();
        test_search_illegal();
        test_en_gap();
        test_err_counter();
        test_reset_locked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
